// File: rtl/instr_encoder.sv
// RV32I R/I-type field-bundle encoder feeding an address-tagged FIFO.
// Optional legality check on accepted bundles: define INSTR_ENC_LEGAL_CHECK_EN.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_type,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_rs1,
  input  logic [4:0]                 in_rs2,
  input  logic [2:0]                 in_funct3,
  input  logic [6:0]                 in_funct7,
  input  logic [11:0]                in_imm,
  input  logic                       in_clear,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_addr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and in_ready depends only on registered count.
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   addr_mem  [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   addr;
  logic [31:0]   word;
  logic          legal, accept, push, pop;

  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign out_instr = instr_mem[rd_ptr];
  assign out_addr  = addr_mem[rd_ptr];

  assign word = in_type ? {in_imm, in_rs1, in_funct3, in_rd, 7'b0010011}
                        : {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};

`ifdef INSTR_ENC_LEGAL_CHECK_EN
  always_comb begin
    legal = 1'b1;
    if (!in_type) begin
      if (in_funct7 != 7'h00 && in_funct7 != 7'h20)
        legal = 1'b0;
      else if (in_funct7 == 7'h20 && in_funct3 != 3'b000 && in_funct3 != 3'b101)
        legal = 1'b0;
    end else begin
      if (in_funct3 == 3'b001 && in_imm[11:5] != 7'h00)
        legal = 1'b0;
      if (in_funct3 == 3'b101 && in_imm[11:5] != 7'h00 && in_imm[11:5] != 7'h20)
        legal = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= accept && !in_clear && !legal;
  end
`else
  assign legal = 1'b1;
  assign err   = 1'b0;
`endif

  assign accept = in_valid && in_ready;
  // Clear wins over both sides: the presented bundle is dropped and nothing pops.
  assign push   = accept && legal && !in_clear;
  assign pop    = out_valid && out_ready && !in_clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      addr   <= BASE_ADDR;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        addr_mem[i]  <= '0;
      end
    end else if (in_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      addr   <= BASE_ADDR;
    end else begin
      if (push) begin
        instr_mem[wr_ptr] <= word;
        addr_mem[wr_ptr]  <= addr;
        wr_ptr            <= wr_ptr + 1'b1;
        addr              <= addr + 32'd4;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a default-base instance and a wrap-base instance.
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_type;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [11:0] in_imm;

  logic        in_valid, in_ready, in_clear, out_valid, out_ready, err;
  logic [31:0] out_instr, out_addr;
  logic [2:0]  count;

  logic        w_in_valid, w_in_ready, w_clear, w_out_valid, w_out_ready, w_err;
  logic [31:0] w_out_instr, w_out_addr;
  logic [2:0]  w_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] wq[$];

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .in_clear(in_clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .count(count), .err(err)
  );

  instr_encoder #(.DEPTH(4), .BASE_ADDR(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .in_clear(w_clear), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_instr(w_out_instr), .out_addr(w_out_addr), .count(w_count), .err(w_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: compare {addr, instr} of every popped head against the expected queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL main_unexpected: got %0h/%0h expected none", out_addr, out_instr);
      end else
        chk("main_pop", {out_addr, out_instr}, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && w_out_valid && w_out_ready) begin
      if (wq.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wrap_unexpected: got %0h/%0h expected none", w_out_addr, w_out_instr);
      end else
        chk("wrap_pop", {w_out_addr, w_out_instr}, wq.pop_front());
    end
  end

  task automatic send(input bit w, input bit typ, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [11:0] imm, input logic [31:0] e_instr,
                      input logic [31:0] e_addr, input bit enq);
    int t;
    in_type = typ; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    if (w) w_in_valid = 1'b1;
    else   in_valid   = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (w ? w_in_ready : in_ready) break;
      t++;
      if (t > 50) begin
        n_checks++;
        n_errors++;
        $display("FAIL send_timeout: got in_ready=0 expected 1");
        break;
      end
    end
    if (enq) begin
      if (w) wq.push_back({e_addr, e_instr});
      else   exp_q.push_back({e_addr, e_instr});
    end
    @(posedge clk); #1;
    in_valid   = 1'b0;
    w_in_valid = 1'b0;
  endtask

  task automatic drain(input bit w, input string name);
    int t;
    t = 0;
    while (t < 50 && (w ? (wq.size() != 0 || w_count != 0) : (exp_q.size() != 0 || count != 0))) begin
      @(posedge clk); #1;
      t++;
    end
    chk(name, w ? wq.size() : exp_q.size(), 0);
  endtask

  initial begin
    logic [31:0] fw [5];
    fw[0] = 32'h002080B3; fw[1] = 32'h00208133; fw[2] = 32'h002081B3;
    fw[3] = 32'h00208233; fw[4] = 32'h002082B3;

    rst_n = 1'b0; in_valid = 0; w_in_valid = 0; in_clear = 0; w_clear = 0;
    out_ready = 0; w_out_ready = 0; in_type = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0;
    in_funct3 = 0; in_funct7 = 0; in_imm = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_count", count, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    out_ready = 1'b1;
    send(0, 0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 12'h0, 32'h002081B3, 32'h0, 1);
    chk("latency_valid", out_valid, 1);
    chk("latency_instr", out_instr, 32'h002081B3);
    send(0, 0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 12'h0, 32'h402081B3, 32'h4, 1);
    send(0, 1, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 12'hFFF, 32'hFFF00293, 32'h8, 1);

`ifdef INSTR_ENC_LEGAL_CHECK_EN
    send(0, 0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h01, 12'h0, 32'h022081B3, 32'hC, 0);
    chk("illegal_err", err, 1);
    chk("illegal_count", count, 0);
    @(posedge clk); #1;
    chk("err_one_cycle", err, 0);
    send(0, 0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 12'h0, 32'h002081B3, 32'hC, 1);
`else
    send(0, 0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h01, 12'h0, 32'h022081B3, 32'hC, 1);
    chk("nocheck_err", err, 0);
    chk("nocheck_count", count, 1);
    @(posedge clk); #1;
    chk("nocheck_err2", err, 0);
    send(0, 0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 12'h0, 32'h002081B3, 32'h10, 1);
`endif
    drain(0, "basic_drain");

    // Mid-stream asynchronous reset discards held entries.
    out_ready = 1'b0;
    send(0, 0, 5'd1, 5'd1, 5'd2, 3'd0, 7'h00, 12'h0, 32'h0, 32'h0, 0);
    send(0, 0, 5'd2, 5'd1, 5'd2, 3'd0, 7'h00, 12'h0, 32'h0, 32'h0, 0);
    chk("pre_reset_count", count, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_addr", out_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill to full with a fifth bundle waiting, then pop once with in_valid held.
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(0, 0, 5'(i + 1), 5'd1, 5'd2, 3'd0, 7'h00, 12'h0, fw[i], 32'(i * 4), 1);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        chk("hold_instr", out_instr, 32'h002080B3);
        chk("hold_addr", out_addr, 32'h0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("full_pop_only", count, 3);
        @(posedge clk); #1;
        chk("push_after_pop", count, 4);
        out_ready = 1'b1;
      end
    join
    drain(0, "full_drain");

    // Address wrap and clear on the second instance.
    w_out_ready = 1'b1;
    send(1, 0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 12'h0, 32'h002081B3, 32'hFFFF_FFF8, 1);
    send(1, 0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 12'h0, 32'h402081B3, 32'hFFFF_FFFC, 1);
    send(1, 1, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 12'hFFF, 32'hFFF00293, 32'h0000_0000, 1);
    drain(1, "wrap_drain");
    w_out_ready = 1'b0;
    send(1, 0, 5'd4, 5'd1, 5'd2, 3'd0, 7'h00, 12'h0, 32'h0, 32'h0, 0);
    send(1, 0, 5'd5, 5'd1, 5'd2, 3'd0, 7'h00, 12'h0, 32'h0, 32'h0, 0);
    chk("pre_clear_count", w_count, 2);
    w_clear = 1'b1;
    w_in_valid = 1'b1;
    #1;
    chk("clear_in_ready", w_in_ready, 1);
    @(posedge clk); #1;
    w_clear = 1'b0;
    w_in_valid = 1'b0;
    chk("clear_valid", w_out_valid, 0);
    chk("clear_count", w_count, 0);
    w_out_ready = 1'b1;
    send(1, 0, 5'd6, 5'd1, 5'd2, 3'd0, 7'h00, 12'h0, 32'h00208333, 32'hFFFF_FFF8, 1);
    drain(1, "clear_drain");
    chk("wrap_err", w_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Buffered RV32I instruction encoder: the inverse of the R/I-type field decoder. Accepts decoded field bundles (rd, rs1, rs2, funct3, funct7, imm) over a valid/ready handshake and packs each into a 32-bit instruction word. Tags each word with an auto-incrementing word address and queues it in a small FIFO. The FIFO drains to the instruction-memory loader over a second valid/ready handshake. Used by the self-test program builder to generate instruction streams for the single-cycle core.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- BASE_ADDR, 32'h0000_0000, address assigned to first word after reset/clear
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept
- in_type  in  1  0 = R-type (opcode 7'b0110011), 1 = I-type ALU (opcode 7'b0010011)
- in_rd / in_rs1 / in_rs2  in  5 each  register indices (in_rs2 ignored for I-type)
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (ignored for I-type)
- in_imm  in  12  immediate (ignored for R-type)
- in_clear  in  1  synchronous flush + address restart
- out_valid  out  1  head entry valid
- out_ready  in  1  loader accepts head
- out_instr  out  32  encoded word at head
- out_addr  out  32  byte address of head word
- count  out  $clog2(DEPTH+1)  entries held
- err  out  1  one-cycle pulse: bundle rejected (see Configuration)

## Operation
- Encoding, R: {funct7, rs2, rs1, funct3, rd, 7'b0110011}; I: {imm[11:0], rs1, funct3, rd, 7'b0010011}.
- Accept when in_valid && in_ready. Encoded word and current addr register are written to tail; tail, count, addr update at that edge.
- addr register: reset/clear to BASE_ADDR; +4 per enqueued word; wraps modulo 2^32 (32'hFFFF_FFFC → 32'h0).
- in_ready = (count != DEPTH); no combinational path from out_ready. When full, a same-cycle pop does not enable a push.
- out_valid = (count != 0); out_instr/out_addr driven from head storage. Pop on out_valid && out_ready.
- Simultaneous push and pop (not full, not empty): count unchanged; both pointers advance; pointers wrap modulo DEPTH.
- in_clear: count, pointers → 0 and addr → BASE_ADDR at next edge. Overrides push and pop in that cycle; a bundle presented then is dropped (in_ready still reads 1 if not full). Storage contents are not cleared.
- Reset mid-stream: all entries discarded immediately (asynchronous), addr → BASE_ADDR.

## Timing
- Reset values: in_ready 1, out_valid 0, out_instr 0, out_addr 0 (storage reset to 0), count 0, err 0.
- Latency: bundle accepted at edge N into an empty FIFO → out_valid, out_instr, out_addr valid after edge N.
- While out_valid && !out_ready, out_instr/out_addr hold stable.
- Throughput: one word per cycle each side, sustained, when neither full nor empty.
- err asserts for exactly one cycle, after the edge that consumed the offending bundle.

## Configuration
- INSTR_ENC_LEGAL_CHECK_EN defined: bundles are legality-checked at accept. Illegal cases:
  - R-type: funct7 ∉ {7'h00, 7'h20}; or funct7 = 7'h20 with funct3 ∉ {3'b000, 3'b101}.
  - I-type: funct3 = 3'b001 with imm[11:5] ≠ 0; funct3 = 3'b101 with imm[11:5] ∉ {7'h00, 7'h20}.
  - An illegal bundle completes the handshake but is not enqueued; addr and count are unchanged; err pulses.
- Not defined: every accepted bundle is encoded and enqueued; err tied 0.

## Test plan
- After reset, push R rd=3 rs1=1 rs2=2 f3=0 f7=0 with out_ready=1 → next cycle out_instr=32'h002081B3, out_addr=0; then f7=7'h20 → 32'h402081B3, out_addr=4.
- Push I rd=5 rs1=0 f3=0 imm=12'hFFF → out_instr=32'hFFF00293.
- out_ready=0, push 5 bundles back-to-back with DEPTH=4 → in_ready drops after 4th, count=4, 5th held; raise out_ready → addrs 0,4,8,12,16 emitted in order, no loss or duplication.
- Full FIFO, in_valid=1, out_ready=1 for one cycle → pop only, count 4→3, push next cycle.
- BASE_ADDR=32'hFFFF_FFF8, push 3 words → addrs FFFF_FFF8, FFFF_FFFC, 0000_0000; in_clear with count=2 → out_valid=0 next cycle, next word at FFFF_FFF8.
- With INSTR_ENC_LEGAL_CHECK_EN: R f7=7'h01 → err one-cycle pulse, count unchanged, next legal word keeps the expected address. Without the macro → word 32'h022081B3 enqueued, err stays 0.
